// File: rtl/bsg_link_ddr_downstream_core_pkg.sv
// Constants and helpers shared by the upstream and downstream halves of the DDR link.
package bsg_link_pkg;

  localparam int bsg_link_lg_fifo_depth_gp       = 6;
  localparam int bsg_link_lg_credit_decimation_gp = 3;

  // Two pad-channel samples (rising and falling edge) form one flit.
  function automatic int bsg_link_flit_width_f(input int channel_width);
    return 2 * channel_width;
  endfunction

endpackage

// File: rtl/bsg_link_ddr_downstream_core_if.sv
// Link-side flit input, core-side word output and the returned credit token.
interface bsg_link_ddr_downstream_core_if #(
  parameter int width_p      = 32,
  parameter int flit_width_p = 16
);
  logic                    link_enable_i;
  logic [flit_width_p-1:0] io_data_i;
  logic                    io_valid_i;
  logic [width_p-1:0]      data_o;
  logic                    valid_o;
  logic                    yumi_i;
  logic                    io_token_r_o;
  logic                    overflow_r_o;

  modport master (
    output link_enable_i, io_data_i, io_valid_i, yumi_i,
    input  data_o, valid_o, io_token_r_o, overflow_r_o
  );

  modport slave (
    input  link_enable_i, io_data_i, io_valid_i, yumi_i,
    output data_o, valid_o, io_token_r_o, overflow_r_o
  );
endinterface

// File: rtl/bsg_link_ddr_downstream_sipo.sv
// Flit-to-word assembler: fills slots low flit first, presents the word with valid_o.
// On yumi_i with a flit available the next word starts loading in the same cycle.
module bsg_link_ddr_downstream_sipo #(
  parameter int width_p      = 32,
  parameter int flit_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [flit_width_p-1:0] flit_i,
  input  logic                    flit_avail_i,
  input  logic                    yumi_i,
  output logic                    deq_o,
  output logic [width_p-1:0]      data_o,
  output logic                    valid_o
);
  localparam int ratio_lp = width_p / flit_width_p;
  localparam int cnt_w_lp = $clog2(ratio_lp + 1);

  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [width_p-1:0]  data_q, data_d;

  assign valid_o = (count_q == cnt_w_lp'(ratio_lp));
  assign deq_o   = flit_avail_i & (~valid_o | yumi_i);
  assign data_o  = data_q;

  always_comb begin
    count_d = count_q;
    data_d  = data_q;
    if (deq_o) begin
      if (valid_o) begin
        data_d[flit_width_p-1:0] = flit_i;
        count_d = cnt_w_lp'(1);
      end else begin
        for (int i = 0; i < ratio_lp; i++) begin
          if (count_q == cnt_w_lp'(i)) data_d[i*flit_width_p +: flit_width_p] = flit_i;
        end
        count_d = count_q + cnt_w_lp'(1);
      end
    end else if (yumi_i && valid_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/bsg_link_fifo_1r1w.sv
// Two-port one-clock FIFO; a write while full is accepted only if a read happens in the same cycle.
// Data is readable the cycle after it is written; deq_i must only be raised while non-empty.
module bsg_link_fifo_1r1w #(
  parameter int width_p    = 16,
  parameter int lg_depth_p = 6
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int cw_lp = lg_depth_p + 1;
  localparam logic [lg_depth_p:0] depth_lp = {1'b1, {lg_depth_p{1'b0}}};

  logic [width_p-1:0]    mem_q [0:(1<<lg_depth_p)-1];
  logic [lg_depth_p-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [lg_depth_p:0]   count_q, count_d;
  logic                  wr_en, rd_en;

  assign full_o  = (count_q == depth_lp);
  assign empty_o = (count_q == '0);
  assign wr_en   = enq_i & (~full_o | deq_i);
  assign rd_en   = deq_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + lg_depth_p'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + lg_depth_p'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + cw_lp'(1);
      2'b01:   count_d = count_q - cw_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/bsg_link_ddr_downstream_core.sv
// Receive core of the DDR link: buffers flits, reassembles core words, returns toggling credit tokens.
// Optional BSG_LINK_DOWNSTREAM_OVERFLOW_CHECK_EN adds a sticky overflow flag and simulation assertions.
module bsg_link_ddr_downstream_core
  import bsg_link_pkg::*;
#(
  parameter int width_p                         = 32,
  parameter int channel_width_p                 = 8,
  parameter int lg_fifo_depth_p                 = bsg_link_lg_fifo_depth_gp,
  parameter int lg_credit_to_token_decimation_p = bsg_link_lg_credit_decimation_gp
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  bsg_link_ddr_downstream_core_if.slave   link_if
);
  localparam int flit_width_lp = bsg_link_flit_width_f(channel_width_p);

  logic                     enq, deq, drop, fifo_full, fifo_empty;
  logic [flit_width_lp-1:0] fifo_data;
  logic [lg_credit_to_token_decimation_p-1:0] drain_cnt_q, drain_cnt_d;
  logic                     token_q, token_d;

  assign enq  = link_if.io_valid_i & link_if.link_enable_i;
  assign drop = enq & fifo_full & ~deq;

  bsg_link_fifo_1r1w #(.width_p(flit_width_lp), .lg_depth_p(lg_fifo_depth_p)) fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .enq_i(enq), .data_i(link_if.io_data_i),
    .deq_i(deq), .data_o(fifo_data),
    .full_o(fifo_full), .empty_o(fifo_empty)
  );

  bsg_link_ddr_downstream_sipo #(.width_p(width_p), .flit_width_p(flit_width_lp)) sipo (
    .clk_i(clk_i), .reset_i(reset_i),
    .flit_i(fifo_data), .flit_avail_i(~fifo_empty),
    .yumi_i(link_if.yumi_i), .deq_o(deq),
    .data_o(link_if.data_o), .valid_o(link_if.valid_o)
  );

  // Credits track drained flits, so the upstream never sees credit for a dropped flit.
  always_comb begin
    drain_cnt_d = drain_cnt_q;
    token_d     = token_q;
    if (deq) begin
      drain_cnt_d = drain_cnt_q + lg_credit_to_token_decimation_p'(1);
      if (&drain_cnt_q) token_d = ~token_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drain_cnt_q <= '0;
      token_q     <= 1'b0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      token_q     <= token_d;
    end
  end

  assign link_if.io_token_r_o = token_q;

`ifdef BSG_LINK_DOWNSTREAM_OVERFLOW_CHECK_EN
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q | drop;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  assign link_if.overflow_r_o = overflow_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!drop) else $warning("link overflow: flit dropped with buffer full");
      assert (!(link_if.yumi_i && !link_if.valid_o)) else $warning("yumi_i raised without valid_o");
    end
  end
`else
  logic unused_drop;
  assign unused_drop          = drop;
  assign link_if.overflow_r_o = 1'b0;
`endif
endmodule

// File: tb/tb_bsg_link_ddr_downstream_core.sv
// Directed bench for the DDR link downstream core at width 32, flit 16, depth 64, 8 flits per token.
module tb_bsg_link_ddr_downstream_core;
  logic clk_i = 1'b0;
  logic reset_i;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  bsg_link_ddr_downstream_core_if #(.width_p(32), .flit_width_p(16)) link_if ();

  bsg_link_ddr_downstream_core #(
    .width_p(32), .channel_width_p(8),
    .lg_fifo_depth_p(6), .lg_credit_to_token_decimation_p(3)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .link_if(link_if)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    link_if.link_enable_i = 1'b1;
    link_if.io_valid_i = 1'b0;
    link_if.io_data_i = '0;
    link_if.yumi_i = 1'b0;
    #12;
    checks++;
    if (link_if.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", link_if.valid_o); end
    checks++;
    if (link_if.io_token_r_o !== 1'b0) begin failures++; $display("FAIL reset_token got=%b exp=0", link_if.io_token_r_o); end
    checks++;
    if (link_if.overflow_r_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", link_if.overflow_r_o); end
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_single_word();
    link_if.io_valid_i = 1'b1;
    link_if.io_data_i = 16'h1111;
    tick();
    link_if.io_data_i = 16'h2222;
    tick();
    link_if.io_valid_i = 1'b0;
    checks++;
    if (link_if.valid_o !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", link_if.valid_o); end
    tick();
    checks++;
    if (link_if.valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", link_if.valid_o); end
    checks++;
    if (link_if.data_o !== 32'h2222_1111) begin failures++; $display("FAIL single_data got=%h exp=22221111", link_if.data_o); end
    link_if.yumi_i = 1'b1;
    tick();
    link_if.yumi_i = 1'b0;
    checks++;
    if (link_if.valid_o !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", link_if.valid_o); end
  endtask

  task automatic test_back_to_back();
    int   words = 0;
    int   toggles = 0;
    logic prev_tok = link_if.io_token_r_o;
    logic [31:0] exp;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (link_if.io_token_r_o !== prev_tok) toggles++;
      prev_tok = link_if.io_token_r_o;
      link_if.yumi_i = link_if.valid_o;
      if (link_if.valid_o === 1'b1) begin
        exp = {16'(32'hA000 + 2*words + 1), 16'(32'hA000 + 2*words)};
        checks++;
        if (link_if.data_o !== exp) begin failures++; $display("FAIL b2b_data word=%0d got=%h exp=%h", words, link_if.data_o, exp); end
        checks++;
        if (cyc != 2*words + 3) begin failures++; $display("FAIL b2b_timing word=%0d got_cycle=%0d exp_cycle=%0d", words, cyc, 2*words + 3); end
        words++;
      end
      link_if.io_valid_i = (cyc < 64);
      link_if.io_data_i = 16'(32'hA000 + cyc);
      tick();
    end
    link_if.io_valid_i = 1'b0;
    link_if.yumi_i = 1'b0;
    checks++;
    if (words != 32) begin failures++; $display("FAIL b2b_words got=%0d exp=32", words); end
    checks++;
    if (toggles != 8) begin failures++; $display("FAIL b2b_toggles got=%0d exp=8", toggles); end
    checks++;
    if (link_if.io_token_r_o !== 1'b0) begin failures++; $display("FAIL b2b_token_end got=%b exp=0", link_if.io_token_r_o); end
  endtask

  task automatic test_overflow();
    int   words = 0;
    logic exp_ovf;
    logic [31:0] exp;
`ifdef BSG_LINK_DOWNSTREAM_OVERFLOW_CHECK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    link_if.yumi_i = 1'b0;
    for (int i = 0; i < 68; i++) begin
      link_if.io_valid_i = 1'b1;
      link_if.io_data_i = 16'(32'hB000 + i);
      tick();
    end
    link_if.io_valid_i = 1'b0;
    tick();
    tick();
    checks++;
    if (link_if.valid_o !== 1'b1 || link_if.data_o !== 32'hB001_B000) begin
      failures++; $display("FAIL ovf_head got=%b/%h exp=1/b001b000", link_if.valid_o, link_if.data_o);
    end
    checks++;
    if (link_if.overflow_r_o !== exp_ovf) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", link_if.overflow_r_o, exp_ovf); end
    for (int cyc = 0; cyc < 100; cyc++) begin
      link_if.yumi_i = link_if.valid_o;
      if (link_if.valid_o === 1'b1) begin
        exp = {16'(32'hB000 + 2*words + 1), 16'(32'hB000 + 2*words)};
        checks++;
        if (link_if.data_o !== exp) begin failures++; $display("FAIL ovf_data word=%0d got=%h exp=%h", words, link_if.data_o, exp); end
        words++;
      end
      tick();
    end
    link_if.yumi_i = 1'b0;
    checks++;
    if (words != 33) begin failures++; $display("FAIL ovf_words got=%0d exp=33", words); end
    checks++;
    if (link_if.overflow_r_o !== exp_ovf) begin failures++; $display("FAIL ovf_sticky got=%b exp=%b", link_if.overflow_r_o, exp_ovf); end
  endtask

  task automatic test_credit();
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    tick();
    checks++;
    if (link_if.io_token_r_o !== 1'b0) begin failures++; $display("FAIL credit_start got=%b exp=0", link_if.io_token_r_o); end
    for (int i = 0; i < 7; i++) begin
      link_if.yumi_i = link_if.valid_o;
      link_if.io_valid_i = 1'b1;
      link_if.io_data_i = 16'(32'hC000 + i);
      tick();
    end
    link_if.io_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      link_if.yumi_i = link_if.valid_o;
      tick();
    end
    link_if.yumi_i = 1'b0;
    checks++;
    if (link_if.io_token_r_o !== 1'b0) begin failures++; $display("FAIL credit_7_flits got=%b exp=0", link_if.io_token_r_o); end
    link_if.io_valid_i = 1'b1;
    link_if.io_data_i = 16'hC007;
    tick();
    link_if.io_valid_i = 1'b0;
    checks++;
    if (link_if.io_token_r_o !== 1'b0) begin failures++; $display("FAIL credit_before_8th got=%b exp=0", link_if.io_token_r_o); end
    tick();
    checks++;
    if (link_if.io_token_r_o !== 1'b1) begin failures++; $display("FAIL credit_8th_toggle got=%b exp=1", link_if.io_token_r_o); end
    checks++;
    if (link_if.valid_o !== 1'b1 || link_if.data_o !== 32'hC007_C006) begin
      failures++; $display("FAIL credit_word got=%b/%h exp=1/c007c006", link_if.valid_o, link_if.data_o);
    end
    link_if.yumi_i = 1'b1;
    tick();
    link_if.yumi_i = 1'b0;
  endtask

  task automatic test_link_disable();
    link_if.link_enable_i = 1'b0;
    link_if.io_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      link_if.io_data_i = 16'(32'hD000 + i);
      tick();
      checks++;
      if (link_if.valid_o !== 1'b0) begin failures++; $display("FAIL disable_valid cyc=%0d got=%b exp=0", i, link_if.valid_o); end
      checks++;
      if (link_if.io_token_r_o !== 1'b1) begin failures++; $display("FAIL disable_token cyc=%0d got=%b exp=1", i, link_if.io_token_r_o); end
    end
    link_if.io_valid_i = 1'b0;
    link_if.link_enable_i = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (link_if.valid_o !== 1'b0) begin failures++; $display("FAIL disable_nothing_buffered got=%b exp=0", link_if.valid_o); end
  endtask

  task automatic test_reset_mid_word();
    link_if.io_valid_i = 1'b1;
    link_if.io_data_i = 16'hE001;
    tick();
    link_if.io_valid_i = 1'b0;
    tick();
    tick();
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (link_if.valid_o !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", link_if.valid_o); end
    checks++;
    if (link_if.io_token_r_o !== 1'b0) begin failures++; $display("FAIL midreset_token got=%b exp=0", link_if.io_token_r_o); end
    checks++;
    if (link_if.overflow_r_o !== 1'b0) begin failures++; $display("FAIL midreset_overflow got=%b exp=0", link_if.overflow_r_o); end
    tick();
    reset_i = 1'b0;
    link_if.io_valid_i = 1'b1;
    link_if.io_data_i = 16'hE111;
    tick();
    link_if.io_data_i = 16'hE222;
    tick();
    link_if.io_valid_i = 1'b0;
    tick();
    checks++;
    if (link_if.valid_o !== 1'b1 || link_if.data_o !== 32'hE222_E111) begin
      failures++; $display("FAIL midreset_clean_word got=%b/%h exp=1/e222e111", link_if.valid_o, link_if.data_o);
    end
    link_if.yumi_i = 1'b1;
    tick();
    link_if.yumi_i = 1'b0;
    checks++;
    if (link_if.valid_o !== 1'b0) begin failures++; $display("FAIL midreset_consumed got=%b exp=0", link_if.valid_o); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_credit();
    test_link_disable();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
